csr_ret_fwd_pipe: RTL and testbench

Tracks in-flight CSR writes between the execute stage and CSR-file commit, and supplies the correct xRET target PC. It forwards the youngest pending write to mepc or sepc, falling back to the architectural CSR value when no write is pending. It also drives the registered commit port into the CSR file. It sits beside the EX/MEM/WB pipeline registers and feeds the PC-select mux on mret/sret.

---
 rtl/csr_ret_fwd_pipe_pkg.sv | 25 ++
 rtl/csr_fwd_match.sv | 25 ++
 rtl/csr_ret_fwd_pipe.sv | 109 ++++++++++
 tb/tb_csr_ret_fwd_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_ret_fwd_pipe_pkg.sv
// Shared CSR addresses, xRET encodings and the in-flight entry layout for the
// CSR write-tracking pipe.
package csr_pkg;

  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_SEPC = 12'h141;

  typedef enum logic {
    RET_MRET = 1'b0,
    RET_SRET = 1'b1
  } ret_kind_e;

  localparam int unsigned CSR_XLEN = 64;

  typedef struct packed {
    logic                valid;
    logic [11:0]         addr;
    logic [CSR_XLEN-1:0] data;
  } csr_entry_t;

  function automatic logic [11:0] ret_target(input logic kind);
    return (kind == RET_SRET) ? CSR_SEPC : CSR_MEPC;
  endfunction

endpackage

// File: rtl/csr_fwd_match.sv
// Youngest-first priority selector: candidate 0 is the youngest and wins
// whenever several candidates match.
module csr_fwd_match #(
  parameter int unsigned N    = 4,
  parameter int unsigned XLEN = 64
) (
  input  logic [N-1:0]           match,
  input  logic [N-1:0][XLEN-1:0] data,
  output logic                   hit,
  output logic [XLEN-1:0]        sel
);

  // Walk oldest to youngest so the last (youngest) match overwrites the rest.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (match[i-1]) begin
        hit = 1'b1;
        sel = data[i-1];
      end
    end
  end

endmodule

// File: rtl/csr_ret_fwd_pipe.sv
// Tracks in-flight CSR writes from EX to CSR-file commit and resolves the
// mret/sret target PC, forwarding the youngest pending mepc/sepc write.
module csr_ret_fwd_pipe
  import csr_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic [11:0]                issue_addr,
  input  logic [XLEN-1:0]            issue_data,
  input  logic                       ret_valid,
  input  logic                       ret_kind,
  input  logic [XLEN-1:0]            mepc_rd,
  input  logic [XLEN-1:0]            sepc_rd,
  output logic [XLEN-1:0]            ret_pc,
  output logic                       ret_fwd,
  output logic                       commit_valid,
  output logic [11:0]                commit_addr,
  output logic [XLEN-1:0]            commit_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                fwd_count
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned NC    = DEPTH + 1;

  typedef struct packed {
    logic            valid;
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t      stg_q [DEPTH];
  logic [31:0] fwd_count_q;

  // On flush the oldest stage commits this cycle, so an unstalled flush
  // empties every stage; a stalled flush keeps the oldest for a later commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else if (stall) begin
      if (flush) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) stg_q[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= '{valid: issue_valid, addr: issue_addr, data: issue_data};
      for (int unsigned i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  logic [11:0]           tgt;
  logic [NC-1:0]         cand_match;
  logic [NC-1:0][XLEN-1:0] cand_data;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;

  always_comb begin
    tgt           = ret_target(ret_kind);
    cand_match    = '0;
    cand_data     = '0;
    cand_match[0] = issue_valid & ~stall & (issue_addr == tgt);
    cand_data[0]  = issue_data;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cand_match[i+1] = stg_q[i].valid & (stg_q[i].addr == tgt);
      cand_data[i+1]  = stg_q[i].data;
    end
  end

  csr_fwd_match #(
    .N    (NC),
    .XLEN (XLEN)
  ) u_match (
    .match (cand_match),
    .data  (cand_data),
    .hit   (fwd_hit),
    .sel   (fwd_data)
  );

  always_comb begin
    ret_pc    = fwd_hit ? fwd_data : ((ret_kind == RET_SRET) ? sepc_rd : mepc_rd);
    ret_fwd   = ret_valid & fwd_hit;
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(stg_q[i].valid);
    end
  end

  assign commit_valid = stg_q[DEPTH-1].valid & ~stall & ~rst;
  assign commit_addr  = stg_q[DEPTH-1].addr;
  assign commit_data  = stg_q[DEPTH-1].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_count_q <= '0;
    end else if (ret_fwd && !stall && (fwd_count_q != '1)) begin
      fwd_count_q <= fwd_count_q + 32'd1;
    end
  end

  assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_csr_ret_fwd_pipe.sv
// Self-checking bench for csr_ret_fwd_pipe (XLEN=64, DEPTH=3): table-driven
// lookup vectors, a commit scoreboard, and hand-written stall/flush/reset runs.
module tb_csr_ret_fwd_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic [11:0] issue_addr = '0;
  logic [63:0] issue_data = '0;
  logic        ret_valid = 1'b0;
  logic        ret_kind = 1'b0;
  logic [63:0] mepc_rd = 64'h8000_0000;
  logic [63:0] sepc_rd = 64'h9000_0000;
  logic [63:0] ret_pc;
  logic        ret_fwd;
  logic        commit_valid;
  logic [11:0] commit_addr;
  logic [63:0] commit_data;
  logic [1:0]  occupancy;
  logic [31:0] fwd_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] a;
    logic [63:0] d;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        iv;
    logic [11:0] ia;
    logic [63:0] id;
    logic        rv;
    logic        rk;
    logic [63:0] e_pc;
    logic        e_fwd;
    logic [1:0]  e_occ;
    logic        e_cv;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t tbl[12];

  csr_ret_fwd_pipe #(
    .XLEN  (64),
    .DEPTH (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_data   (issue_data),
    .ret_valid    (ret_valid),
    .ret_kind     (ret_kind),
    .mepc_rd      (mepc_rd),
    .sepc_rd      (sepc_rd),
    .ret_pc       (ret_pc),
    .ret_fwd      (ret_fwd),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .occupancy    (occupancy),
    .fwd_count    (fwd_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Inputs change 1 time unit after the rising edge; control returns at the
  // following falling edge, where outputs are stable for checking.
  task automatic drive(input logic r, input logic s, input logic f, input logic iv,
                       input logic [11:0] ia, input logic [63:0] id,
                       input logic rv, input logic rk);
    @(posedge clk);
    #1;
    rst = r; stall = s; flush = f;
    issue_valid = iv; issue_addr = ia; issue_data = id;
    ret_valid = rv; ret_kind = rk;
    if (iv && !s && !f && !r) sb.push_back('{a: ia, d: id});
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (commit_valid) begin
      if (sb.size() == 0) begin
        chk("commit_unexpected", 64'(commit_valid), 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("commit_addr", 64'(commit_addr), 64'(e.a));
        chk("commit_data", commit_data, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 12'h341, 64'h8000_1000, 1'b0, 1'b0, 64'h8000_1000, 1'b0, 2'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 12'h000, 64'h0,         1'b1, 1'b0, 64'h8000_1000, 1'b1, 2'd1, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 12'h141, 64'h100,       1'b1, 1'b1, 64'h100,       1'b1, 2'd1, 1'b0, 32'd1};
    tbl[3]  = '{1'b1, 12'h141, 64'h200,       1'b1, 1'b1, 64'h200,       1'b1, 2'd2, 1'b1, 32'd2};
    tbl[4]  = '{1'b0, 12'h000, 64'h0,         1'b1, 1'b1, 64'h200,       1'b1, 2'd2, 1'b0, 32'd3};
    tbl[5]  = '{1'b0, 12'h000, 64'h0,         1'b0, 1'b0, 64'h8000_0000, 1'b0, 2'd2, 1'b1, 32'd4};
    tbl[6]  = '{1'b1, 12'h300, 64'hDEAD,      1'b1, 1'b0, 64'h8000_0000, 1'b0, 2'd1, 1'b1, 32'd4};
    tbl[7]  = '{1'b1, 12'h341, 64'h5000,      1'b1, 1'b1, 64'h9000_0000, 1'b0, 2'd1, 1'b0, 32'd4};
    tbl[8]  = '{1'b0, 12'h000, 64'h0,         1'b1, 1'b0, 64'h5000,      1'b1, 2'd2, 1'b0, 32'd4};
    tbl[9]  = '{1'b0, 12'h000, 64'h0,         1'b0, 1'b1, 64'h9000_0000, 1'b0, 2'd2, 1'b1, 32'd5};
    tbl[10] = '{1'b0, 12'h000, 64'h0,         1'b1, 1'b1, 64'h9000_0000, 1'b0, 2'd1, 1'b1, 32'd5};
    tbl[11] = '{1'b0, 12'h000, 64'h0,         1'b0, 1'b0, 64'h8000_0000, 1'b0, 2'd0, 1'b0, 32'd5};

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_addr", 64'(commit_addr), 64'd0);
    chk("rst_commit_data", commit_data, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_fwd_count", 64'(fwd_count), 64'd0);
    chk("rst_ret_pc", ret_pc, 64'h8000_0000);
    chk("rst_ret_fwd", 64'(ret_fwd), 64'd0);

    // Forwarding, youngest-wins, kind isolation, commit latency
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, tbl[i].iv, tbl[i].ia, tbl[i].id, tbl[i].rv, tbl[i].rk);
      chk($sformatf("tbl%0d_ret_pc", i), ret_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_ret_fwd", i), 64'(ret_fwd), 64'(tbl[i].e_fwd));
      chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_commit_valid", i), 64'(commit_valid), 64'(tbl[i].e_cv));
      chk($sformatf("tbl%0d_fwd_count", i), 64'(fwd_count), 64'(tbl[i].e_cnt));
    end

    // Stall: entry held in stage 1, issue during stall dropped
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hA000, 1'b0, 1'b0);
    idle();
    chk("stl_occ_pre", 64'(occupancy), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h141, 64'hB000, 1'b1, 1'b1);
    chk("stl_commit0", 64'(commit_valid), 64'd0);
    chk("stl_occ0", 64'(occupancy), 64'd1);
    chk("stl_issue_ignored_pc", ret_pc, 64'h9000_0000);
    chk("stl_issue_ignored_fwd", 64'(ret_fwd), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    chk("stl_fwd_pc", ret_pc, 64'hA000);
    chk("stl_fwd", 64'(ret_fwd), 64'd1);
    chk("stl_commit1", 64'(commit_valid), 64'd0);
    chk("stl_occ1", 64'(occupancy), 64'd1);
    idle();
    chk("stl_rel_occ", 64'(occupancy), 64'd1);
    chk("stl_rel_commit", 64'(commit_valid), 64'd0);
    chk("stl_cnt_held", 64'(fwd_count), 64'd5);
    idle();
    chk("stl_commit_after", 64'(commit_valid), 64'd1);
    idle();
    chk("stl_occ_end", 64'(occupancy), 64'd0);
    chk("stl_commit_end", 64'(commit_valid), 64'd0);

    // Flush with all three stages full
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hF0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h141, 64'hF1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hF2, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'h141, 64'hF3, 1'b0, 1'b0);
    chk("fl_commit", 64'(commit_valid), 64'd1);
    chk("fl_commit_data", commit_data, 64'hF0);
    chk("fl_occ", 64'(occupancy), 64'd3);
    #1;
    sb.delete();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    chk("fl_occ_after", 64'(occupancy), 64'd0);
    chk("fl_ret_pc", ret_pc, 64'h8000_0000);
    chk("fl_ret_fwd", 64'(ret_fwd), 64'd0);
    chk("fl_commit_after", 64'(commit_valid), 64'd0);

    // Stall together with flush: oldest stage holds, younger stages cleared
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hC0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h141, 64'hC1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hC2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 64'h0, 1'b0, 1'b0);
    chk("sf_commit", 64'(commit_valid), 64'd0);
    chk("sf_occ", 64'(occupancy), 64'd3);
    #1;
    sb.delete(2);
    sb.delete(1);
    idle();
    chk("sf_occ_after", 64'(occupancy), 64'd1);
    chk("sf_commit_after", 64'(commit_valid), 64'd1);
    chk("sf_commit_data", commit_data, 64'hC0);
    idle();
    chk("sf_occ_end", 64'(occupancy), 64'd0);

    // Saturation of fwd_count
    force dut.fwd_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.fwd_count_q;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hD0, 1'b1, 1'b0);
    chk("sat_cnt0", 64'(fwd_count), 64'hFFFF_FFFD);
    chk("sat_fwd0", 64'(ret_fwd), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    chk("sat_cnt1", 64'(fwd_count), 64'hFFFF_FFFE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    chk("sat_cnt2", 64'(fwd_count), 64'hFFFF_FFFF);
    chk("sat_pc2", ret_pc, 64'hD0);
    idle();
    chk("sat_cnt3", 64'(fwd_count), 64'hFFFF_FFFF);

    // Reset with entries pending
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hE0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h141, 64'hE1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h341, 64'hE2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b0);
    chk("mrst_commit", 64'(commit_valid), 64'd0);
    #1;
    sb.delete();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 1'b1);
    chk("mrst_occ", 64'(occupancy), 64'd0);
    chk("mrst_commit_valid", 64'(commit_valid), 64'd0);
    chk("mrst_commit_addr", 64'(commit_addr), 64'd0);
    chk("mrst_commit_data", commit_data, 64'd0);
    chk("mrst_fwd_count", 64'(fwd_count), 64'd0);
    chk("mrst_ret_pc", ret_pc, 64'h9000_0000);
    chk("mrst_ret_fwd", 64'(ret_fwd), 64'd0);
    idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
